rv32i_exec_unit: RTL and testbench

RV32I_EXEC_UNIT -- requirements
Module: rv32i_exec_unit

---
 rtl/rv32i_exec_unit.sv | 118 +++++++++++
 tb/tb_rv32i_exec_unit.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_exec_unit.sv
// RV32I execute stage: immediate decode, integer ALU and branch compare, with the
// ALU result and branch flag also presented one cycle later through a register.
`timescale 1ns/1ps
module rv32i_exec_unit (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] inst,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic [31:0] imm,
  output logic [31:0] result,
  output logic        take_b,
  output logic [31:0] result_q,
  output logic        take_b_q
);

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpRimm   = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpSystem = 7'b1110011;

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic        w_alt;
  logic [4:0]  w_shamt;
  logic [31:0] w_sum;
  logic [31:0] w_diff;
  logic        w_eq;
  logic        w_lt_s;
  logic        w_lt_u;
  logic [31:0] w_imm;
  logic [31:0] w_result;
  logic        w_take_b;

  logic [31:0] r_result;
  logic        r_take_b;

  assign w_opcode = inst[6:0];
  assign w_funct3 = inst[14:12];
  assign w_alt    = inst[30];
  assign w_shamt  = in_b[4:0];

  assign w_sum  = in_a + in_b;
  assign w_diff = in_a - in_b;
  assign w_eq   = (in_a == in_b);
  assign w_lt_s = ($signed(in_a) < $signed(in_b));
  assign w_lt_u = (in_a < in_b);

  always_comb begin
    w_imm = 32'h0;
    case (w_opcode)
      OpRimm, OpLoad, OpJalr, OpSystem: w_imm = {{20{inst[31]}}, inst[31:20]};
      OpStore:         w_imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      OpBranch:        w_imm = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
      OpLui, OpAuipc:  w_imm = {inst[31:12], 12'h000};
      OpJal:           w_imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
      default:         w_imm = 32'h0;
    endcase
  end

  // Address/link arithmetic (JAL, JALR, AUIPC, loads, stores, ...) all reduce to a plain add.
  always_comb begin
    w_result = w_sum;
    if (w_opcode == OpLui) begin
      w_result = w_imm;
    end else if ((w_opcode == OpR) || (w_opcode == OpRimm)) begin
      case (w_funct3)
        3'b000:  w_result = ((w_opcode == OpR) && w_alt) ? w_diff : w_sum;
        3'b001:  w_result = in_a << w_shamt;
        3'b010:  w_result = {31'h0, w_lt_s};
        3'b011:  w_result = {31'h0, w_lt_u};
        3'b100:  w_result = in_a ^ in_b;
        3'b101:  w_result = w_alt ? $unsigned($signed(in_a) >>> w_shamt) : (in_a >> w_shamt);
        3'b110:  w_result = in_a | in_b;
        3'b111:  w_result = in_a & in_b;
        default: w_result = w_sum;
      endcase
    end
  end

  always_comb begin
    w_take_b = 1'b0;
    if (w_opcode == OpBranch) begin
      case (w_funct3)
        3'b000:  w_take_b = w_eq;
        3'b001:  w_take_b = ~w_eq;
        3'b100:  w_take_b = w_lt_s;
        3'b101:  w_take_b = ~w_lt_s;
        3'b110:  w_take_b = w_lt_u;
        3'b111:  w_take_b = ~w_lt_u;
        default: w_take_b = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_result <= 32'h0;
      r_take_b <= 1'b0;
    end else begin
      r_result <= w_result;
      r_take_b <= w_take_b;
    end
  end

  assign imm      = w_imm;
  assign result   = w_result;
  assign take_b   = w_take_b;
  assign result_q = r_result;
  assign take_b_q = r_take_b;

endmodule

// File: tb/tb_rv32i_exec_unit.sv
// Self-checking bench for rv32i_exec_unit: directed vectors plus a random
// back-to-back stream, registered outputs checked through a scoreboard queue.
`timescale 1ns/1ps
module tb_rv32i_exec_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] inst;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [31:0] imm;
  logic [31:0] result;
  logic        take_b;
  logic [31:0] result_q;
  logic        take_b_q;

  int errors = 0;
  int checks = 0;

  // Scoreboard entry: {take_b, result} expected on the registered outputs.
  logic [32:0] sb_q[$];

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [31:0] imm;
    logic        tb;
  } vec_t;

  always #5 clk = ~clk;

  rv32i_exec_unit dut (
    .clk      (clk),
    .resetn   (resetn),
    .inst     (inst),
    .in_a     (in_a),
    .in_b     (in_b),
    .imm      (imm),
    .result   (result),
    .take_b   (take_b),
    .result_q (result_q),
    .take_b_q (take_b_q)
  );

  // Independent reference model of the execute stage.
  function automatic void model(input logic [31:0] i, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] r,
                                output logic t, output logic [31:0] im);
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [4:0]  sh;
    logic [63:0] ext;
    op = i[6:0];
    f3 = i[14:12];
    sh = b[4:0];
    im = 32'h0;
    if (op == 7'h13 || op == 7'h03 || op == 7'h67 || op == 7'h73)
      im = {{20{i[31]}}, i[31:20]};
    else if (op == 7'h23)
      im = {{20{i[31]}}, i[31:25], i[11:7]};
    else if (op == 7'h63)
      im = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    else if (op == 7'h37 || op == 7'h17)
      im = {i[31:12], 12'h000};
    else if (op == 7'h6f)
      im = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    r = a + b;
    if (op == 7'h37) begin
      r = im;
    end else if (op == 7'h33 || op == 7'h13) begin
      case (f3)
        3'd0: if (op == 7'h33 && i[30]) r = a + ~b + 32'd1;
        3'd1: r = a << sh;
        3'd2: r = {31'h0, (a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)};
        3'd3: r = {31'h0, a < b};
        3'd4: r = a ^ b;
        3'd5: begin
          ext = {{32{i[30] & a[31]}}, a};
          ext = ext >> sh;
          r   = ext[31:0];
        end
        3'd6: r = a | b;
        3'd7: r = a & b;
        default: r = a + b;
      endcase
    end
    t = 1'b0;
    if (op == 7'h63) begin
      case (f3)
        3'd0: t = (a == b);
        3'd1: t = (a != b);
        3'd4: t = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000));
        3'd5: t = !((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000));
        3'd6: t = (a < b);
        3'd7: t = !(a < b);
        default: t = 1'b0;
      endcase
    end
  endfunction

  task automatic test_reset();
    logic [32:0] exp;
    resetn = 1'b0;
    inst   = 32'h0000_0063;  // BEQ, equal operands: take_b=1, result=10
    in_a   = 32'd5;
    in_b   = 32'd5;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (result_q !== 32'h0) begin
      errors++;
      $display("FAIL reset_result_q: got %h want %h", result_q, 32'h0);
    end
    checks++;
    if (take_b_q !== 1'b0) begin
      errors++;
      $display("FAIL reset_take_b_q: got %b want 0", take_b_q);
    end
    checks++;
    if (result !== 32'd10 || take_b !== 1'b1) begin
      errors++;
      $display("FAIL reset_comb: result=%h take_b=%b want 0000000a/1", result, take_b);
    end
    @(negedge clk);
    resetn = 1'b1;
    sb_q.push_back({1'b1, 32'd10});
    #1;
    checks++;
    if (result_q !== 32'h0) begin
      errors++;
      $display("FAIL release_early: result_q=%h want 00000000", result_q);
    end
    @(posedge clk);
    #1;
    exp = sb_q.pop_front();
    checks++;
    if ({take_b_q, result_q} !== exp) begin
      errors++;
      $display("FAIL release_first: got %h want %h", {take_b_q, result_q}, exp);
    end
  endtask

  task automatic test_alu();
    vec_t v[$];
    logic [32:0] exp;
    v.push_back('{32'h40B5_0533, 32'd5,         32'd7,         32'hFFFF_FFFE, 32'h0,         1'b0});
    v.push_back('{32'h00B5_0533, 32'h7FFF_FFFF, 32'd1,         32'h8000_0000, 32'h0,         1'b0});
    v.push_back('{32'h40B5_0533, 32'd0,         32'd1,         32'hFFFF_FFFF, 32'h0,         1'b0});
    v.push_back('{32'h4005_0513, 32'd0,         32'd1,         32'h0000_0001, 32'h400,       1'b0});
    v.push_back('{32'h4045_5513, 32'h8000_0000, 32'd4,         32'hF800_0000, 32'h404,       1'b0});
    v.push_back('{32'h0045_5513, 32'h8000_0000, 32'd4,         32'h0800_0000, 32'h4,         1'b0});
    v.push_back('{32'h00B5_1533, 32'd1,         32'hFFFF_FFE3, 32'h0000_0008, 32'h0,         1'b0});
    v.push_back('{32'h40B5_5533, 32'h8000_0000, 32'hFFFF_FFE1, 32'hC000_0000, 32'h0,         1'b0});
    v.push_back('{32'h00B5_2533, 32'hFFFF_FFFF, 32'd1,         32'h0000_0001, 32'h0,         1'b0});
    v.push_back('{32'h00B5_3533, 32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 32'h0,         1'b0});
    v.push_back('{32'h00B5_4533, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0,         1'b0});
    v.push_back('{32'h00B5_6533, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0, 32'h0,         1'b0});
    v.push_back('{32'h00B5_7533, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 32'h0,         1'b0});
    foreach (v[k]) begin
      @(negedge clk);
      inst = v[k].inst;
      in_a = v[k].a;
      in_b = v[k].b;
      sb_q.push_back({v[k].tb, v[k].res});
      #1;
      checks++;
      if (result !== v[k].res) begin
        errors++;
        $display("FAIL alu_result[%0d]: got %h want %h", k, result, v[k].res);
      end
      checks++;
      if (imm !== v[k].imm) begin
        errors++;
        $display("FAIL alu_imm[%0d]: got %h want %h", k, imm, v[k].imm);
      end
      checks++;
      if (take_b !== v[k].tb) begin
        errors++;
        $display("FAIL alu_take_b[%0d]: got %b want %b", k, take_b, v[k].tb);
      end
      @(posedge clk);
      #1;
      exp = sb_q.pop_front();
      checks++;
      if ({take_b_q, result_q} !== exp) begin
        errors++;
        $display("FAIL alu_registered[%0d]: got %h want %h", k, {take_b_q, result_q}, exp);
      end
    end
  endtask

  task automatic test_imm_decode();
    vec_t v[$];
    logic [32:0] exp;
    v.push_back('{32'hFFDF_F06F, 32'h100,  32'd4,         32'h0000_0104, 32'hFFFF_FFFC, 1'b0});
    v.push_back('{32'h1234_50B7, 32'hDEAD, 32'hBEEF,      32'h1234_5000, 32'h1234_5000, 1'b0});
    v.push_back('{32'hFE11_2E23, 32'h1000, 32'hFFFF_FFFC, 32'h0000_0FFC, 32'hFFFF_FFFC, 1'b0});
    v.push_back('{32'h0000_0517, 32'h100,  32'd4,         32'h0000_0104, 32'h0,         1'b0});
    v.push_back('{32'hFE00_0EE3, 32'd3,    32'd3,         32'h0000_0006, 32'hFFFF_FFFC, 1'b1});
    v.push_back('{32'h8000_2503, 32'h1000, 32'hFFFF_F800, 32'h0000_0800, 32'hFFFF_F800, 1'b0});
    v.push_back('{32'hFFC5_0567, 32'd8,    32'd4,         32'h0000_000C, 32'hFFFF_FFFC, 1'b0});
    v.push_back('{32'h0000_007F, 32'd2,    32'd3,         32'h0000_0005, 32'h0,         1'b0});
    foreach (v[k]) begin
      @(negedge clk);
      inst = v[k].inst;
      in_a = v[k].a;
      in_b = v[k].b;
      sb_q.push_back({v[k].tb, v[k].res});
      #1;
      checks++;
      if (imm !== v[k].imm) begin
        errors++;
        $display("FAIL imm_decode[%0d]: got %h want %h", k, imm, v[k].imm);
      end
      checks++;
      if (result !== v[k].res || take_b !== v[k].tb) begin
        errors++;
        $display("FAIL imm_result[%0d]: got %h/%b want %h/%b", k, result, take_b,
                 v[k].res, v[k].tb);
      end
      @(posedge clk);
      #1;
      exp = sb_q.pop_front();
      checks++;
      if ({take_b_q, result_q} !== exp) begin
        errors++;
        $display("FAIL imm_registered[%0d]: got %h want %h", k, {take_b_q, result_q}, exp);
      end
    end
  endtask

  task automatic test_branch();
    vec_t v[$];
    logic [32:0] exp;
    v.push_back('{32'h0000_4063, 32'hFFFF_FFFF, 32'd1,         32'h0, 32'h0, 1'b1});
    v.push_back('{32'h0000_6063, 32'hFFFF_FFFF, 32'd1,         32'h0, 32'h0, 1'b0});
    v.push_back('{32'h0000_5063, 32'hFFFF_FFFF, 32'd1,         32'h0, 32'h0, 1'b0});
    v.push_back('{32'h0000_5063, 32'd1,         32'hFFFF_FFFF, 32'h0, 32'h0, 1'b1});
    v.push_back('{32'h0000_7063, 32'hFFFF_FFFF, 32'd1,         32'h0, 32'h0, 1'b1});
    v.push_back('{32'h0000_1063, 32'd5,         32'd5,         32'hA, 32'h0, 1'b0});
    v.push_back('{32'h0000_0063, 32'd5,         32'd5,         32'hA, 32'h0, 1'b1});
    v.push_back('{32'h0000_2063, 32'd5,         32'd5,         32'hA, 32'h0, 1'b0});
    v.push_back('{32'h0000_3063, 32'd5,         32'd5,         32'hA, 32'h0, 1'b0});
    v.push_back('{32'h00B5_0533, 32'd5,         32'd5,         32'hA, 32'h0, 1'b0});
    v.push_back('{32'h0000_5063, 32'd5,         32'd5,         32'hA, 32'h0, 1'b1});
    v.push_back('{32'h0000_4063, 32'd5,         32'd5,         32'hA, 32'h0, 1'b0});
    foreach (v[k]) begin
      @(negedge clk);
      inst = v[k].inst;
      in_a = v[k].a;
      in_b = v[k].b;
      sb_q.push_back({v[k].tb, v[k].res});
      #1;
      checks++;
      if (take_b !== v[k].tb) begin
        errors++;
        $display("FAIL branch_take_b[%0d]: got %b want %b", k, take_b, v[k].tb);
      end
      checks++;
      if (result !== v[k].res) begin
        errors++;
        $display("FAIL branch_result[%0d]: got %h want %h", k, result, v[k].res);
      end
      @(posedge clk);
      #1;
      exp = sb_q.pop_front();
      checks++;
      if ({take_b_q, result_q} !== exp) begin
        errors++;
        $display("FAIL branch_registered[%0d]: got %h want %h", k, {take_b_q, result_q}, exp);
      end
    end
  endtask

  task automatic test_reset_midstream();
    logic [32:0] exp;
    @(negedge clk);
    inst = 32'h40B5_0533;
    in_a = 32'd5;
    in_b = 32'd7;
    @(posedge clk);
    #1;
    checks++;
    if (result_q !== 32'hFFFF_FFFE) begin
      errors++;
      $display("FAIL mid_pre: result_q=%h want fffffffe", result_q);
    end
    @(negedge clk);
    resetn = 1'b0;
    #1;
    checks++;
    if (result_q !== 32'hFFFF_FFFE) begin
      errors++;
      $display("FAIL mid_sync: result_q=%h want fffffffe before edge", result_q);
    end
    checks++;
    if (result !== 32'hFFFF_FFFE) begin
      errors++;
      $display("FAIL mid_comb: result=%h want fffffffe", result);
    end
    @(posedge clk);
    #1;
    checks++;
    if (result_q !== 32'h0 || take_b_q !== 1'b0) begin
      errors++;
      $display("FAIL mid_cleared: got %h/%b want 00000000/0", result_q, take_b_q);
    end
    @(negedge clk);
    inst = 32'h0000_0063;
    in_a = 32'd9;
    in_b = 32'd9;
    @(posedge clk);
    #1;
    checks++;
    if (result_q !== 32'h0 || take_b_q !== 1'b0) begin
      errors++;
      $display("FAIL mid_held: got %h/%b want 00000000/0", result_q, take_b_q);
    end
    @(negedge clk);
    resetn = 1'b1;
    sb_q.push_back({1'b1, 32'd18});
    @(posedge clk);
    #1;
    exp = sb_q.pop_front();
    checks++;
    if ({take_b_q, result_q} !== exp) begin
      errors++;
      $display("FAIL mid_release: got %h want %h", {take_b_q, result_q}, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0]  ops [11];
    logic [31:0] rnd;
    logic [31:0] er;
    logic [31:0] eim;
    logic        et;
    logic [32:0] exp;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h73, 7'h7F};
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (n > 0) begin
        exp = sb_q.pop_front();
        checks++;
        if ({take_b_q, result_q} !== exp) begin
          errors++;
          $display("FAIL b2b_registered[%0d]: got %h want %h", n - 1, {take_b_q, result_q}, exp);
        end
      end
      rnd  = $urandom();
      inst = {rnd[31:7], ops[$urandom_range(0, 10)]};
      in_a = $urandom();
      in_b = ($urandom_range(0, 3) == 0) ? in_a : $urandom();
      model(inst, in_a, in_b, er, et, eim);
      sb_q.push_back({et, er});
      #1;
      checks++;
      if (result !== er || take_b !== et || imm !== eim) begin
        errors++;
        $display("FAIL b2b_comb[%0d]: inst=%h got %h/%b/%h want %h/%b/%h", n, inst,
                 result, take_b, imm, er, et, eim);
      end
    end
    @(negedge clk);
    exp = sb_q.pop_front();
    checks++;
    if ({take_b_q, result_q} !== exp) begin
      errors++;
      $display("FAIL b2b_registered_last: got %h want %h", {take_b_q, result_q}, exp);
    end
  endtask

  initial begin
    resetn = 1'b0;
    inst   = 32'h0;
    in_a   = 32'h0;
    in_b   = 32'h0;
    test_reset();
    test_alu();
    test_imm_decode();
    test_branch();
    test_reset_midstream();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
